// File: rtl/inst_fetch_pkg.sv
// Shared CPU definitions: fetch FSM encoding, reset vector and MIPS instruction field positions.
// Decode and the main controller import the field helpers from here as well.
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    OUT  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

  function automatic logic [5:0] opcode_of(input logic [31:0] word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

  function automatic logic [5:0] funct_of(input logic [31:0] word);
    return word[FUNCT_MSB:FUNCT_LSB];
  endfunction

endpackage

// File: rtl/inst_fetch.sv
// MIPS fetch stage: owns the PC, keeps one instruction-memory request in flight and
// holds the returned word for decode. Redirects squash at most one stale response.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_plus4
);

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_next;
  logic [31:0]  fetch_pc, fetch_pc_next;
  logic         kill, kill_next;
  logic [31:0]  inst_next, inst_pc_next;
  logic [31:0]  target;

  // Low two target bits are dropped so pc stays word aligned.
  assign target        = redirect_target & ~32'h3;
  assign imem_req      = (state == REQ) && !redirect && !reset;
  assign imem_addr     = pc;
  assign inst_valid    = (state == OUT);
  assign inst_pc_plus4 = inst_pc + 32'd4;

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    fetch_pc_next = fetch_pc;
    kill_next     = kill;
    inst_next     = inst;
    inst_pc_next  = inst_pc;
    case (state)
      REQ: begin
        if (redirect) begin
          pc_next = target;
        end else if (imem_ready) begin
          fetch_pc_next = pc;
          pc_next       = pc + 32'd4;
          state_next    = WAIT;
        end
      end
      WAIT: begin
        if (redirect) pc_next = target;
        // A response racing a redirect, or owed to an earlier one, is stale.
        if (imem_rvalid && (kill || redirect)) begin
          kill_next  = 1'b0;
          state_next = REQ;
        end else if (imem_rvalid) begin
          inst_next    = imem_rdata;
          inst_pc_next = fetch_pc;
          state_next   = OUT;
        end else if (redirect) begin
          kill_next = 1'b1;
        end
      end
      OUT: begin
        if (redirect) begin
          pc_next    = target;
          state_next = REQ;
        end else if (inst_ready) begin
          state_next = REQ;
        end
      end
      default: state_next = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= REQ;
      pc       <= RESET_PC;
      fetch_pc <= 32'd0;
      kill     <= 1'b0;
      inst     <= 32'd0;
      inst_pc  <= 32'd0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      fetch_pc <= fetch_pc_next;
      kill     <= kill_next;
      inst     <= inst_next;
      inst_pc  <= inst_pc_next;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: zero-wait fetches, memory and decode stalls,
// redirects in every state, reset mid-fetch and PC wrap-around.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;

  int checks   = 0;
  int failures = 0;

  inst_fetch #(.RESET_PC(32'h0040_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_pc_plus4  (inst_pc_plus4)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete zero-wait fetch from REQ at addr, consumed immediately by decode.
  task automatic applyStimulus(input logic [31:0] addr);
    imem_ready = 1'b1; imem_rvalid = 1'b0; inst_ready = 1'b0; #1;
    checkOutput("zw_req", imem_req, 1'b1);
    checkOutput("zw_addr", imem_addr, addr);
    checkOutput("zw_idle_valid", inst_valid, 1'b0);
    step();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = addr ^ 32'hA5A5_0000; #1;
    checkOutput("zw_wait_req", imem_req, 1'b0);
    checkOutput("zw_wait_valid", inst_valid, 1'b0);
    step();
    imem_rvalid = 1'b0; inst_ready = 1'b1; #1;
    checkOutput("zw_out_valid", inst_valid, 1'b1);
    checkOutput("zw_inst", inst, addr ^ 32'hA5A5_0000);
    checkOutput("zw_inst_pc", inst_pc, addr);
    checkOutput("zw_pc_plus4", inst_pc_plus4, addr + 32'd4);
    checkOutput("zw_out_req", imem_req, 1'b0);
    step();
    inst_ready = 1'b0; #1;
    checkOutput("zw_after_valid", inst_valid, 1'b0);
  endtask

  initial begin
    reset = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    redirect = 1'b0; redirect_target = 32'd0; inst_ready = 1'b0;

    // Reset state
    step(); step();
    checkOutput("rst_req", imem_req, 1'b0);
    checkOutput("rst_valid", inst_valid, 1'b0);
    checkOutput("rst_inst", inst, 32'd0);
    checkOutput("rst_inst_pc", inst_pc, 32'd0);
    checkOutput("rst_addr", imem_addr, 32'h0040_0000);
    imem_ready = 1'b1; #1;
    checkOutput("rst_req_ready", imem_req, 1'b0);
    imem_ready = 1'b0;
    reset = 1'b0;

    // Three zero-wait fetches, one instruction every third cycle
    applyStimulus(32'h0040_0000);
    applyStimulus(32'h0040_0004);
    applyStimulus(32'h0040_0008);

    // Memory not ready for 4 cycles, response 3 cycles after acceptance
    reset = 1'b1; step(); reset = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("stall_req", imem_req, 1'b1);
      checkOutput("stall_addr", imem_addr, 32'h0040_0000);
      step();
    end
    imem_ready = 1'b1; #1;
    checkOutput("stall_accept_addr", imem_addr, 32'h0040_0000);
    step();
    imem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checkOutput("slow_wait_req", imem_req, 1'b0);
      checkOutput("slow_wait_valid", inst_valid, 1'b0);
      step();
    end
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    imem_rvalid = 1'b0; #1;
    checkOutput("slow_valid", inst_valid, 1'b1);
    checkOutput("slow_inst", inst, 32'h1234_5678);
    checkOutput("slow_inst_pc", inst_pc, 32'h0040_0000);

    // Decode stalls 5 cycles while the instruction is held
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("hold_valid", inst_valid, 1'b1);
      checkOutput("hold_inst", inst, 32'h1234_5678);
      checkOutput("hold_inst_pc", inst_pc, 32'h0040_0000);
      checkOutput("hold_req", imem_req, 1'b0);
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0; #1;
    checkOutput("hold_release_valid", inst_valid, 1'b0);
    checkOutput("hold_next_addr", imem_addr, 32'h0040_0004);
    checkOutput("hold_next_req", imem_req, 1'b1);

    // Redirect in WAIT with the stale response 2 cycles later
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0; redirect = 1'b1; redirect_target = 32'h0040_1003;
    step();
    redirect = 1'b0; #1;
    checkOutput("kill_wait_req", imem_req, 1'b0);
    checkOutput("kill_addr", imem_addr, 32'h0040_1000);
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0; #1;
    checkOutput("kill_valid", inst_valid, 1'b0);
    checkOutput("kill_req", imem_req, 1'b1);
    checkOutput("kill_next_addr", imem_addr, 32'h0040_1000);
    step();
    checkOutput("kill_valid_later", inst_valid, 1'b0);
    applyStimulus(32'h0040_1000);

    // Redirect coinciding with inst_ready in OUT drops the held instruction
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_F00D;
    step();
    imem_rvalid = 1'b0; #1;
    checkOutput("out_redir_valid", inst_valid, 1'b1);
    checkOutput("out_redir_inst_pc", inst_pc, 32'h0040_1004);
    redirect = 1'b1; redirect_target = 32'h0040_2000; inst_ready = 1'b1;
    step();
    redirect = 1'b0; inst_ready = 1'b0; #1;
    checkOutput("out_redir_drop", inst_valid, 1'b0);
    checkOutput("out_redir_addr", imem_addr, 32'h0040_2000);
    checkOutput("out_redir_req", imem_req, 1'b1);

    // Redirect while memory is ready in REQ: no acceptance that cycle
    imem_ready = 1'b1; redirect = 1'b1; redirect_target = 32'h0040_3002; #1;
    checkOutput("req_redir_req", imem_req, 1'b0);
    step();
    redirect = 1'b0; #1;
    checkOutput("req_redir_req_after", imem_req, 1'b1);
    checkOutput("req_redir_addr", imem_addr, 32'h0040_3000);
    applyStimulus(32'h0040_3000);

    // Reset during WAIT, then a late response
    imem_ready = 1'b1;
    step();
    reset = 1'b1; #1;
    checkOutput("rst_wait_req", imem_req, 1'b0);
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_0001; #1;
    checkOutput("rst_hold_req", imem_req, 1'b0);
    step();
    reset = 1'b0; imem_ready = 1'b0;
    step();
    imem_rvalid = 1'b0; #1;
    checkOutput("late_valid", inst_valid, 1'b0);
    checkOutput("late_inst", inst, 32'd0);
    checkOutput("late_addr", imem_addr, 32'h0040_0000);
    checkOutput("late_req", imem_req, 1'b1);

    // PC wrap-around at the top of the address space
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFF;
    step();
    redirect = 1'b0;
    applyStimulus(32'hFFFF_FFFC);
    checkOutput("wrap_addr", imem_addr, 32'h0000_0000);
    checkOutput("wrap_plus4", inst_pc_plus4, 32'h0000_0000);
    checkOutput("wrap_req", imem_req, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
